// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with jump/branch/sequential next-value
// selection, IF/ID pipeline register with squash, and saturating counters of
// stall and flush cycles for performance monitoring.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PcWrite,
   input  logic             IRWrite,
   input  logic             flush,
   input  logic             PcSrc,
   input  logic             Jmp,
   input  logic [31:0]      branchAdr,
   input  logic [31:0]      jmpAdr,
   input  logic [31:0]      instIn,
   output logic [31:0]      instAdr,
   output logic [31:0]      IR,
   output logic [31:0]      pcPlus4,
   output logic             ifIdValid,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   // Word-aligned reset PC; the low two bits of the PC are never set.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0]      r_pc;
   logic [31:0]      r_ir;
   logic [31:0]      r_pc_plus4;
   logic             r_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_pc_target;
   logic [31:0]      w_pc_next;

   assign w_pc_plus4 = r_pc + 32'd4;

   // Next-PC selection: jump beats taken branch beats sequential fetch.
   always_comb begin
      w_pc_target = w_pc_plus4;
      if (Jmp) begin
         w_pc_target = jmpAdr;
      end else if (PcSrc) begin
         w_pc_target = branchAdr;
      end
      w_pc_next = {w_pc_target[31:2], 2'b00};
   end

   // PC register: loads the selected next value only when the hazard unit allows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= RESET_PC_ALIGNED;
      end else if (PcWrite) begin
         r_pc <= w_pc_next;
      end
   end

   // IF/ID register: squash has priority over load; otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ir       <= '0;
         r_pc_plus4 <= '0;
         r_valid    <= 1'b0;
      end else if (flush) begin
         r_ir       <= '0;
         r_pc_plus4 <= '0;
         r_valid    <= 1'b0;
      end else if (IRWrite) begin
         r_ir       <= instIn;
         r_pc_plus4 <= w_pc_plus4;
         r_valid    <= 1'b1;
      end
   end

   // Stall and flush event counters, each saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!PcWrite && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign instAdr   = r_pc;
   assign IR        = r_ir;
   assign pcPlus4   = r_pc_plus4;
   assign ifIdValid = r_valid;
   assign stallCnt  = r_stall_cnt;
   assign flushCnt  = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        PcWrite, IRWrite, flush, PcSrc, Jmp;
   logic [31:0] branchAdr, jmpAdr;

   logic [31:0] instIn0, instAdr0, IR0, pcPlus40;
   logic        ifIdValid0;
   logic [15:0] stallCnt0, flushCnt0;

   logic [31:0] instIn1, instAdr1, IR1, pcPlus41;
   logic        ifIdValid1;
   logic [2:0]  stallCnt1, flushCnt1;

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = default instance, 1 = small-counter instance
   logic [31:0] m_pc   [2];
   logic [31:0] m_ir   [2];
   logic [31:0] m_pp4  [2];
   logic        m_v    [2];
   int          m_stall[2];
   int          m_flush[2];
   logic [31:0] n_pc   [2];
   logic [31:0] n_ir   [2];
   logic [31:0] n_pp4  [2];
   logic        n_v    [2];
   int          n_stall[2];
   int          n_flush[2];

   localparam logic [31:0] RP1 = 32'h0000_1000;
   logic [31:0] rst_pc [2] = '{32'h0, RP1};
   int          cmax   [2] = '{65535, 7};

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign instIn0 = mem(instAdr0);
   assign instIn1 = mem(instAdr1);

   fetch_stage dut0 (
      .clk(clk), .rst(rst), .PcWrite(PcWrite), .IRWrite(IRWrite), .flush(flush),
      .PcSrc(PcSrc), .Jmp(Jmp), .branchAdr(branchAdr), .jmpAdr(jmpAdr),
      .instIn(instIn0), .instAdr(instAdr0), .IR(IR0), .pcPlus4(pcPlus40),
      .ifIdValid(ifIdValid0), .stallCnt(stallCnt0), .flushCnt(flushCnt0)
   );

   fetch_stage #(.RESET_PC(RP1), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .PcWrite(PcWrite), .IRWrite(IRWrite), .flush(flush),
      .PcSrc(PcSrc), .Jmp(Jmp), .branchAdr(branchAdr), .jmpAdr(jmpAdr),
      .instIn(instIn1), .instAdr(instAdr1), .IR(IR1), .pcPlus4(pcPlus41),
      .ifIdValid(ifIdValid1), .stallCnt(stallCnt1), .flushCnt(flushCnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, " instAdr0"},  instAdr0,          m_pc[0]);
      check({ctx, " IR0"},       IR0,               m_ir[0]);
      check({ctx, " pcPlus40"},  pcPlus40,          m_pp4[0]);
      check({ctx, " valid0"},    {31'b0, ifIdValid0}, {31'b0, m_v[0]});
      check({ctx, " stall0"},    {16'b0, stallCnt0}, m_stall[0]);
      check({ctx, " flush0"},    {16'b0, flushCnt0}, m_flush[0]);
      check({ctx, " instAdr1"},  instAdr1,          m_pc[1]);
      check({ctx, " IR1"},       IR1,               m_ir[1]);
      check({ctx, " pcPlus41"},  pcPlus41,          m_pp4[1]);
      check({ctx, " valid1"},    {31'b0, ifIdValid1}, {31'b0, m_v[1]});
      check({ctx, " stall1"},    {29'b0, stallCnt1}, m_stall[1]);
      check({ctx, " flush1"},    {29'b0, flushCnt1}, m_flush[1]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = rst_pc[k]; m_ir[k] = '0; m_pp4[k] = '0; m_v[k] = 1'b0;
         m_stall[k] = 0; m_flush[k] = 0;
      end
   endtask

   task automatic set_in(input logic pw, input logic iw, input logic fl,
                         input logic ps, input logic jp,
                         input logic [31:0] ba, input logic [31:0] ja);
      PcWrite = pw; IRWrite = iw; flush = fl; PcSrc = ps; Jmp = jp;
      branchAdr = ba; jmpAdr = ja;
   endtask

   // One clock edge with reset released: predict, clock, commit, compare.
   task automatic cycle(input string ctx);
      for (int k = 0; k < 2; k++) begin
         n_ir[k] = m_ir[k]; n_pp4[k] = m_pp4[k]; n_v[k] = m_v[k];
         if (flush) begin
            n_ir[k] = '0; n_pp4[k] = '0; n_v[k] = 1'b0;
         end else if (IRWrite) begin
            n_ir[k] = mem(m_pc[k]); n_pp4[k] = m_pc[k] + 32'd4; n_v[k] = 1'b1;
         end
         n_pc[k] = m_pc[k];
         if (PcWrite) begin
            if (Jmp)        n_pc[k] = jmpAdr & ~32'h3;
            else if (PcSrc) n_pc[k] = branchAdr & ~32'h3;
            else            n_pc[k] = m_pc[k] + 32'd4;
         end
         n_stall[k] = (!PcWrite && m_stall[k] < cmax[k]) ? m_stall[k] + 1 : m_stall[k];
         n_flush[k] = (flush && m_flush[k] < cmax[k]) ? m_flush[k] + 1 : m_flush[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = n_pc[k]; m_ir[k] = n_ir[k]; m_pp4[k] = n_pp4[k]; m_v[k] = n_v[k];
         m_stall[k] = n_stall[k]; m_flush[k] = n_flush[k];
      end
      check_all(ctx);
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0F00, 32'h0000_0E00);
      model_reset();
      @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // Sequential fetch from reset
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("seq1");
      check("seq1 instAdr const", instAdr0, 32'd4);
      check("seq1 valid const", {31'b0, ifIdValid0}, 32'd1);
      cycle("seq2");
      check("seq2 pcPlus4 const", pcPlus40, 32'd8);
      cycle("seq3");
      check("seq3 instAdr const", instAdr0, 32'd12);
      check("seq3 pcPlus4 const", pcPlus40, 32'd12);

      // Jump to 0x40 then stall two edges
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40);
      cycle("jmp40");
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h600);
      cycle("stall1");
      cycle("stall2");
      check("stall hold pc const", instAdr0, 32'h40);
      check("stall count const", {16'b0, stallCnt0}, 32'd2);

      // Taken branch with squash, misaligned target
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h103, 32'h0);
      cycle("brflush");
      check("brflush pc const", instAdr0, 32'h100);
      check("brflush IR const", IR0, 32'h0);
      check("brflush count const", {16'b0, flushCnt0}, 32'd1);

      // Jump wins over branch
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h200);
      cycle("jmpprio");
      check("jmpprio pc const", instAdr0, 32'h200);

      // PC wrap at top of address space
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
      cycle("jmptop");
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("wrap");
      check("wrap pc const", instAdr0, 32'h0);
      check("wrap pcPlus4 const", pcPlus40, 32'h0);

      // Drive the small instance's counters into saturation
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) cycle("sat");
      check("sat stall1 const", {29'b0, stallCnt1}, 32'd7);
      check("sat flush1 const", {29'b0, flushCnt1}, 32'd7);

      // Reset pulse between edges during a stall
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("prestall");
      rst = 1'b0;
      #2;
      model_reset();
      check_all("asyncrst");
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 32'h800);
      @(posedge clk);
      #1;
      check_all("rsthold");
      rst = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("postrst");
      check("postrst pc const", instAdr0, 32'd4);
      check("postrst pc1 const", instAdr1, RP1 + 32'd4);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 6) == 0), $urandom, $urandom);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
